// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - on-chip golden-model response checker for the add/sub adder
//
// Purpose: accepts PAT_LENGTH patterns of {mode, a, b} plus the adder's sum/overflow,
//          recomputes the golden result one cycle after capture, counts pass/fail,
//          remembers the first failing pattern index, then holds the verdict in DONE.
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   start                     begin/restart a run (ignored while busy)
//   in_valid / in_ready       pattern handshake; in_ready high only in RUN
//   in_mode, in_a, in_b       stimulus given to the adder (mode 1 = add, 0 = subtract)
//   in_sum, in_overflow       adder response under test
//   pass_cnt, fail_cnt        per-run match / mismatch counts
//   first_fail_vld/_idx       first mismatch seen and its 0-based pattern index
//   busy, done, all_pass      run status; done/all_pass are registered
module adder_result_checker #(
  parameter int WIDTH      = 8,
  parameter int PAT_LENGTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_overflow,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             busy,
  output logic             done,
  output logic             all_pass
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_inc;
  logic             accept;
  logic             last_pat;
  logic             clear_run;

  // Stage register: captured pattern, compared in the following cycle
  logic             stg_vld;
  logic             stg_mode;
  logic [WIDTH-1:0] stg_a;
  logic [WIDTH-1:0] stg_b;
  logic [WIDTH-1:0] stg_sum;
  logic             stg_ovf;
  logic [CNT_W-1:0] stg_idx;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] exp_sum;
  logic             exp_ovf;
  logic             match;

  logic [CNT_W-1:0] pass_nxt;
  logic [CNT_W-1:0] fail_nxt;
  logic             ffv_nxt;
  logic [CNT_W-1:0] ffi_nxt;

  assign in_ready  = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign accept    = in_valid && in_ready;
  assign idx_inc   = idx + CNT_W'(1);
  assign last_pat  = (idx_inc == CNT_W'(PAT_LENGTH));
  // start in IDLE/DONE opens a new run; in_ready is low there, so a
  // simultaneous in_valid is never accepted on the start cycle.
  assign clear_run = start && ((state == S_IDLE) || (state == S_DONE));

  // Golden model at WIDTH+1 bits; subtraction reports no borrow flag.
  assign add_full = {1'b0, stg_a} + {1'b0, stg_b};
  assign sub_full = {1'b0, stg_a} - {1'b0, stg_b};
  assign exp_sum  = stg_mode ? add_full[WIDTH-1:0] : sub_full[WIDTH-1:0];
  assign exp_ovf  = stg_mode & add_full[WIDTH];
  // An X/Z response makes match non-true, which lands in the fail branch.
  assign match    = (stg_sum == exp_sum) && (stg_ovf == exp_ovf);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && last_pat) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pass_nxt = pass_cnt;
    fail_nxt = fail_cnt;
    ffv_nxt  = first_fail_vld;
    ffi_nxt  = first_fail_idx;
    if (clear_run) begin
      pass_nxt = '0;
      fail_nxt = '0;
      ffv_nxt  = 1'b0;
      ffi_nxt  = '0;
    end else if (stg_vld) begin
      if (match) begin
        pass_nxt = pass_cnt + CNT_W'(1);
      end else begin
        fail_nxt = fail_cnt + CNT_W'(1);
        if (!first_fail_vld) begin
          ffv_nxt = 1'b1;
          ffi_nxt = stg_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      stg_vld        <= 1'b0;
      stg_mode       <= 1'b0;
      stg_a          <= '0;
      stg_b          <= '0;
      stg_sum        <= '0;
      stg_ovf        <= 1'b0;
      stg_idx        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
    end else begin
      state   <= state_nxt;
      stg_vld <= accept;
      if (accept) begin
        stg_mode <= in_mode;
        stg_a    <= in_a;
        stg_b    <= in_b;
        stg_sum  <= in_sum;
        stg_ovf  <= in_overflow;
        stg_idx  <= idx;
      end
      if (clear_run) begin
        idx <= '0;
      end else if (accept) begin
        idx <= idx_inc;
      end
      pass_cnt       <= pass_nxt;
      fail_cnt       <= fail_nxt;
      first_fail_vld <= ffv_nxt;
      first_fail_idx <= ffi_nxt;
      // DRAIN retires the last compare on the same edge that enters DONE,
      // so the verdict uses the next-state counts.
      done           <= (state_nxt == S_DONE);
      all_pass       <= (state_nxt == S_DONE) && (fail_nxt == '0);
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// tb/tb_adder_result_checker.sv - scoreboard bench for adder_result_checker
module tb_adder_result_checker;
  localparam int W = 8;
  localparam int P = 4;
  localparam int C = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst_n, start, in_valid, in_ready, in_mode, in_overflow;
  logic [W-1:0] in_a, in_b, in_sum;
  logic [C-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic         first_fail_vld, busy, done, all_pass;

  adder_result_checker #(.WIDTH(W), .PAT_LENGTH(P), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_overflow(in_overflow),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx), .busy(busy), .done(done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  typedef struct {logic ok; int idx;} exp_t;
  exp_t exp_q[$];

  int n_pass = 0, n_fail = 0, n_total = 0;
  int m_st = M_IDLE, m_pass = 0, m_fail = 0, m_idx = 0, m_ffi = 0, m_acc = 0;
  logic m_ffv = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_idx = 0; m_ffv = 1'b0; m_ffi = 0;
    exp_q.delete();
  endtask

  // One clock: push expectation on accept, retire the compare one edge later.
  task automatic tick();
    int sz, s, es, eo, nxt;
    logic acc, r, clr;
    exp_t e;
    sz  = exp_q.size();
    r   = rst_n;
    acc = in_valid && (m_st == M_RUN);
    clr = 1'b0;
    nxt = m_st;
    if (acc) begin
      if (in_mode) begin
        s  = int'(in_a) + int'(in_b);
        es = s % 256;
        eo = (s > 255) ? 1 : 0;
      end else begin
        es = (int'(in_a) - int'(in_b) + 256) % 256;
        eo = 0;
      end
      e.ok  = (int'(in_sum) == es) && (int'(in_overflow) == eo);
      e.idx = m_idx;
      exp_q.push_back(e);
      m_idx++;
      m_acc++;
    end
    case (m_st)
      M_IDLE:  if (start) begin nxt = M_RUN; clr = 1'b1; end
      M_RUN:   if (acc && m_idx == P) nxt = M_DRAIN;
      M_DRAIN: nxt = M_DONE;
      default: if (start) begin nxt = M_RUN; clr = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    if (!r) begin
      model_clear();
      m_st = M_IDLE;
    end else begin
      if (sz > 0) begin
        e = exp_q.pop_front();
        if (e.ok) m_pass++;
        else begin
          m_fail++;
          if (!m_ffv) begin m_ffv = 1'b1; m_ffi = e.idx; end
        end
        check("sb_pass_cnt", pass_cnt, m_pass);
        check("sb_fail_cnt", fail_cnt, m_fail);
        check("sb_first_fail_vld", first_fail_vld, m_ffv);
        if (m_ffv) check("sb_first_fail_idx", first_fail_idx, m_ffi);
      end
      if (clr) model_clear();
      m_st = nxt;
    end
    check("in_ready", in_ready, m_st == M_RUN);
    check("busy", busy, (m_st == M_RUN) || (m_st == M_DRAIN));
    check("done", done, m_st == M_DONE);
    check("all_pass", all_pass, (m_st == M_DONE) && (m_fail == 0));
  endtask

  task automatic set_pat(input logic m, input int a, input int b, input int s, input logic o);
    in_mode = m; in_a = W'(a); in_b = W'(b); in_sum = W'(s); in_overflow = o;
  endtask

  task automatic pat(input logic m, input int a, input int b, input int s, input logic o);
    set_pat(m, a, b, s, o);
    in_valid = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic good4();
    pat(1, 3, 5, 8, 0); pat(0, 10, 3, 7, 0); pat(1, 200, 100, 44, 1); pat(0, 0, 1, 255, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    set_pat(0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    check("reset_pass_cnt", pass_cnt, 0);
    check("reset_fail_cnt", fail_cnt, 0);
    check("reset_ffv", first_fail_vld, 0);
    check("reset_ffi", first_fail_idx, 0);
    tick();

    // 1: four correct patterns, done two cycles after the 4th accept
    do_start();
    good4();
    in_valid = 1'b0;
    check("t1_done_in_drain", done, 0);
    check("t1_busy_in_drain", busy, 1);
    tick();
    check("t1_done", done, 1);
    check("t1_pass", pass_cnt, 4);
    check("t1_fail", fail_cnt, 0);
    check("t1_all_pass", all_pass, 1);
    tick();

    // 2: pattern 2 wrong sum, pattern 4 wrong overflow
    do_start();
    pat(1, 3, 5, 8, 0); pat(0, 10, 3, 9, 0); pat(1, 200, 100, 44, 1); pat(0, 0, 1, 255, 1);
    in_valid = 1'b0;
    tick();
    check("t2_pass", pass_cnt, 2);
    check("t2_fail", fail_cnt, 2);
    check("t2_ffv", first_fail_vld, 1);
    check("t2_ffi", first_fail_idx, 1);
    check("t2_all_pass", all_pass, 0);

    // 3a: in_valid high across start, RUN, DRAIN and DONE; extra garbage must not count
    m_acc = 0;
    set_pat(1, 1, 1, 0, 1);
    in_valid = 1'b1;
    do_start();
    good4();
    set_pat(1, 1, 1, 0, 1);
    check("t3_ready_drain", in_ready, 0);
    tick(); tick(); tick();
    check("t3_ready_done", in_ready, 0);
    in_valid = 1'b0;
    check("t3_accepts", m_acc, 4);
    check("t3_pass", pass_cnt, 4);
    check("t3_fail", fail_cnt, 0);
    // 3b: gaps between patterns
    do_start();
    pat(1, 3, 5, 8, 0);     in_valid = 1'b0; tick();
    pat(0, 10, 3, 7, 0);    in_valid = 1'b0; tick(); tick();
    pat(1, 200, 100, 44, 1); in_valid = 1'b0; tick();
    pat(0, 0, 1, 255, 0);   in_valid = 1'b0; tick();
    check("t3b_pass", pass_cnt, 4);
    check("t3b_all_pass", all_pass, 1);

    // 4: reset mid-run with one fail counted and one compare in flight
    do_start();
    pat(1, 3, 5, 9, 0); pat(0, 10, 3, 7, 0);
    check("t4_fail_before_rst", fail_cnt, 1);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4_rst_pass", pass_cnt, 0);
    check("t4_rst_fail", fail_cnt, 0);
    check("t4_rst_ffv", first_fail_vld, 0);
    check("t4_rst_busy", busy, 0);
    tick();
    do_start();
    good4();
    in_valid = 1'b0;
    tick();
    check("t4_pass", pass_cnt, 4);
    check("t4_ffv", first_fail_vld, 0);

    // 5: start during RUN ignored; restart from DONE scores independently
    do_start();
    pat(1, 3, 5, 8, 0); pat(0, 10, 3, 7, 0);
    start = 1'b1;
    pat(1, 200, 100, 44, 1);
    start = 1'b0;
    pat(0, 0, 1, 255, 0);
    in_valid = 1'b0;
    tick();
    check("t5_pass_no_restart", pass_cnt, 4);
    do_start();
    check("t5_cleared", pass_cnt, 0);
    pat(1, 3, 5, 8, 0); pat(0, 10, 3, 7, 0); pat(1, 200, 100, 45, 1); pat(0, 0, 1, 255, 0);
    in_valid = 1'b0;
    tick();
    check("t5_pass", pass_cnt, 3);
    check("t5_fail", fail_cnt, 1);
    check("t5_ffi", first_fail_idx, 2);

    // 6: edge operands, then the same vectors with overflow inverted
    do_start();
    pat(1, 255, 255, 254, 1); pat(0, 0, 255, 1, 0); pat(1, 128, 128, 0, 1); pat(1, 0, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    check("t6_pass", pass_cnt, 4);
    check("t6_all_pass", all_pass, 1);
    do_start();
    pat(1, 255, 255, 254, 0); pat(0, 0, 255, 1, 1); pat(1, 128, 128, 0, 0); pat(1, 0, 0, 0, 1);
    in_valid = 1'b0;
    tick();
    check("t6_inv_fail", fail_cnt, 4);
    check("t6_inv_pass", pass_cnt, 0);
    check("t6_inv_ffi", first_fail_idx, 0);
    check("t6_inv_all_pass", all_pass, 0);
    check("sb_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
